// File: rtl/reqgnt_monitor.sv
// rtl/reqgnt_monitor.sv - passive multi-channel request/grant protocol monitor
module reqgnt_monitor #(
    parameter int N_CH       = 4,
    parameter int MAX_OUT    = 4,
    parameter int MAX_LAT    = 8,
    parameter int SAME_CYCLE = 1,
    parameter int CNTW       = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req,
    input  logic [N_CH-1:0]      gnt,
    output logic [N_CH*CNTW-1:0] outstanding,
    output logic [N_CH-1:0]      err_spurious,
    output logic [N_CH-1:0]      err_timeout,
    output logic [N_CH-1:0]      err_overflow,
    output logic                 err_sticky,
    output logic                 idle
);

    // Ages only need to count up to MAX_LAT; the oldest entry is dropped there.
    localparam int AW = $clog2(MAX_LAT + 1);

    function automatic logic [AW-1:0] age_inc(input logic [AW-1:0] a);
        return (a == AW'(MAX_LAT)) ? a : a + AW'(1);
    endfunction

    logic [N_CH-1:0] zero_n;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CNTW-1:0] cnt_q, cnt_n;
        logic [AW-1:0]   age_q [MAX_OUT];
        logic [AW-1:0]   age_n [MAX_OUT];
        logic            spur_q, spur_n;
        logic            tmo_q, tmo_n;
        logic            ovf_q, ovf_n;
        logic            retire, serve_new, enq;
        int              ci, head, drop, rem;

        // Queue is kept oldest-first at index 0; grant, timeout and enqueue are
        // applied in that order and the survivors are shifted down by the drops.
        always_comb begin
            ci        = int'(cnt_q);
            retire    = gnt[c] && (ci > 0);
            serve_new = gnt[c] && (ci == 0) && (SAME_CYCLE != 0) && req[c];
            spur_n    = gnt[c] && !retire && !serve_new;
            head      = retire ? 1 : 0;
            tmo_n     = 1'b0;
            for (int k = 0; k < MAX_OUT; k++) begin
                if (k == head && k < ci && age_q[k] == AW'(MAX_LAT - 1)) begin
                    tmo_n = 1'b1;
                end
            end
            drop  = head + (tmo_n ? 1 : 0);
            rem   = ci - drop;
            enq   = req[c] && !serve_new;
            ovf_n = enq && (rem == MAX_OUT);
            // Slots at and above rem come out as age 0, which is also the
            // correct age for a newly enqueued request landing at slot rem.
            for (int k = 0; k < MAX_OUT; k++) begin
                age_n[k] = '0;
                for (int j = 0; j < MAX_OUT; j++) begin
                    if (j == k + drop && j < ci) begin
                        age_n[k] = age_inc(age_q[j]);
                    end
                end
            end
            cnt_n = CNTW'(rem + ((enq && !ovf_n) ? 1 : 0));
        end

        // Per-channel queue state and registered error pulses.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q  <= '0;
                spur_q <= 1'b0;
                tmo_q  <= 1'b0;
                ovf_q  <= 1'b0;
                for (int k = 0; k < MAX_OUT; k++) begin
                    age_q[k] <= '0;
                end
            end else begin
                cnt_q  <= cnt_n;
                spur_q <= spur_n;
                tmo_q  <= tmo_n;
                ovf_q  <= ovf_n;
                for (int k = 0; k < MAX_OUT; k++) begin
                    age_q[k] <= age_n[k];
                end
            end
        end

        assign outstanding[c*CNTW +: CNTW] = cnt_q;
        assign err_spurious[c]             = spur_q;
        assign err_timeout[c]              = tmo_q;
        assign err_overflow[c]             = ovf_q;
        assign zero_n[c]                   = (cnt_n == '0);
    end

    // Idle follows the registered counts; sticky latches any reported pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle       <= 1'b1;
            err_sticky <= 1'b0;
        end else begin
            idle       <= &zero_n;
            err_sticky <= err_sticky | (|err_spurious) | (|err_timeout) | (|err_overflow);
        end
    end

endmodule
